// File: rtl/led_matrix_scroller.sv
// -----------------------------------------------------------------------------
// led_matrix_scroller
//
// Purpose:
//   Column-multiplexed LED matrix controller with a per-row circular message
//   buffer. One column is lit at a time for SCAN_DIV clocks. The visible window
//   is COLS consecutive message positions starting at the scroll pointer. The
//   pointer steps left or right once every SCROLL_FRAMES full frames, and wraps
//   around the MSG_LEN-bit buffer.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset, clears all state
//   mode       in   00 blank, 01 scroll left, 10 scroll right, 11 static
//   load_en    in   write strobe for the message buffer (single-cycle write,
//                   no handshake; rows outside 0..ROWS-1 are ignored)
//   load_row   in   target buffer row for a load
//   load_data  in   row pattern, MSB = message position 0
//   row_out    out  row drive for the active column, active-high
//   col_out    out  one-hot column select, active-high
//   frame_tick out  one-cycle pulse closing each full column scan
// -----------------------------------------------------------------------------
module led_matrix_scroller #(
    parameter int ROWS          = 5,
    parameter int COLS          = 7,
    parameter int MSG_LEN       = 16,
    parameter int SCAN_DIV      = 4,
    parameter int SCROLL_FRAMES = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               mode,
    input  logic                     load_en,
    input  logic [$clog2(ROWS)-1:0]  load_row,
    input  logic [MSG_LEN-1:0]       load_data,
    output logic [ROWS-1:0]          row_out,
    output logic [COLS-1:0]          col_out,
    output logic                     frame_tick
);

    // Counter widths are kept at least one bit so that divide-by-one settings
    // still elaborate cleanly.
    localparam int SCAN_W = (SCAN_DIV > 1)      ? $clog2(SCAN_DIV)      : 1;
    localparam int FRM_W  = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
    localparam int COL_W  = (COLS > 1)          ? $clog2(COLS)          : 1;
    localparam int PTR_W  = (MSG_LEN > 1)       ? $clog2(MSG_LEN)       : 1;
    localparam int SUM_W  = PTR_W + 1;

    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_W'(SCROLL_FRAMES - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(MSG_LEN - 1);
    localparam logic [SUM_W-1:0]  SUM_WRAP  = SUM_W'(MSG_LEN);

    localparam logic [1:0] MODE_BLANK  = 2'b00;
    localparam logic [1:0] MODE_LEFT   = 2'b01;
    localparam logic [1:0] MODE_RIGHT  = 2'b10;
    localparam logic [1:0] MODE_STATIC = 2'b11;

    // State
    logic [MSG_LEN-1:0] r_buf [ROWS];
    logic [PTR_W-1:0]   r_ptr;
    logic [SCAN_W-1:0]  r_scan_cnt;
    logic [COL_W-1:0]   r_col_idx;
    logic [FRM_W-1:0]   r_frame_cnt;
    logic [ROWS-1:0]    r_row_out;
    logic [COLS-1:0]    r_col_out;
    logic               r_frame_tick;

    // Combinational helpers
    logic               w_scan_last;
    logic               w_col_last;
    logic               w_frame_end;
    logic               w_load_ok;
    logic [PTR_W-1:0]   w_ptr_next;
    logic [SUM_W-1:0]   w_sum;
    logic [PTR_W-1:0]   w_k;
    logic [PTR_W-1:0]   w_bit;
    logic [ROWS-1:0]    w_row_pix;
    logic [COLS-1:0]    w_col_onehot;

    assign w_scan_last = (r_scan_cnt == SCAN_LAST);
    assign w_col_last  = (r_col_idx == COL_LAST);
    assign w_frame_end = w_scan_last && w_col_last;
    assign w_load_ok   = load_en && (int'(load_row) < ROWS);

    // Pointer step applied at a scroll event; static and blank hold it.
    always_comb begin
        w_ptr_next = r_ptr;
        case (mode)
            MODE_LEFT:  w_ptr_next = (r_ptr == PTR_LAST) ? '0 : r_ptr + PTR_W'(1);
            MODE_RIGHT: w_ptr_next = (r_ptr == '0) ? PTR_LAST : r_ptr - PTR_W'(1);
            MODE_STATIC,
            MODE_BLANK: w_ptr_next = r_ptr;
            default:    w_ptr_next = r_ptr;
        endcase
    end

    // Message position of the active column: (ptr + col_idx) mod MSG_LEN.
    // Both operands are below MSG_LEN, so one conditional subtract is enough.
    // Position 0 lives in the MSB, hence the final PTR_LAST - k.
    always_comb begin
        w_sum = SUM_W'(r_ptr) + SUM_W'(r_col_idx);
        if (w_sum >= SUM_WRAP) begin
            w_k = PTR_W'(w_sum - SUM_WRAP);
        end else begin
            w_k = PTR_W'(w_sum);
        end
        w_bit = PTR_LAST - w_k;
        for (int r = 0; r < ROWS; r++) begin
            w_row_pix[r] = r_buf[r][w_bit];
        end
    end

    always_comb begin
        w_col_onehot = '0;
        for (int c = 0; c < COLS; c++) begin
            w_col_onehot[c] = (r_col_idx == COL_W'(c));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr        <= '0;
            r_scan_cnt   <= '0;
            r_col_idx    <= '0;
            r_frame_cnt  <= '0;
            r_row_out    <= '0;
            r_col_out    <= '0;
            r_frame_tick <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                r_buf[r] <= '0;
            end
        end else begin
            // Scan timing runs in every mode so blank periods keep frame rhythm.
            r_scan_cnt <= w_scan_last ? '0 : r_scan_cnt + SCAN_W'(1);
            if (w_scan_last) begin
                r_col_idx <= w_col_last ? '0 : r_col_idx + COL_W'(1);
            end

            r_frame_tick <= w_frame_end;

            if (w_frame_end) begin
                if (r_frame_cnt == FRM_LAST) begin
                    r_frame_cnt <= '0;
                    r_ptr       <= w_ptr_next;
                end else begin
                    r_frame_cnt <= r_frame_cnt + FRM_W'(1);
                end
            end

            // Row and column lines update on the same edge to avoid ghosting.
            if (mode == MODE_BLANK) begin
                r_col_out <= '0;
                r_row_out <= '0;
            end else begin
                r_col_out <= w_col_onehot;
                r_row_out <= w_row_pix;
            end

            if (w_load_ok) begin
                r_buf[load_row] <= load_data;
            end
        end
    end

    assign row_out    = r_row_out;
    assign col_out    = r_col_out;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_led_matrix_scroller.sv
// -----------------------------------------------------------------------------
// tb_led_matrix_scroller
//
// Directed bench for led_matrix_scroller with ROWS=5, COLS=7, MSG_LEN=16,
// SCAN_DIV=1, SCROLL_FRAMES=1: each clock lights the next column and the
// pointer moves once per 7-clock frame in the scroll modes.
// -----------------------------------------------------------------------------
module tb_led_matrix_scroller;

    localparam int ROWS          = 5;
    localparam int COLS          = 7;
    localparam int MSG_LEN       = 16;
    localparam int SCAN_DIV      = 1;
    localparam int SCROLL_FRAMES = 1;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic        load_en;
    logic [2:0]  load_row;
    logic [15:0] load_data;
    logic [4:0]  row_out;
    logic [6:0]  col_out;
    logic        frame_tick;

    always #5 clk = ~clk;

    led_matrix_scroller #(
        .ROWS          (ROWS),
        .COLS          (COLS),
        .MSG_LEN       (MSG_LEN),
        .SCAN_DIV      (SCAN_DIV),
        .SCROLL_FRAMES (SCROLL_FRAMES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .load_en    (load_en),
        .load_row   (load_row),
        .load_data  (load_data),
        .row_out    (row_out),
        .col_out    (col_out),
        .frame_tick (frame_tick)
    );

    // ---------------- scoreboard state ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          ft_count;
    logic [15:0] m_buf [5];
    logic [2:0]  m_col;
    logic [3:0]  m_ptr;
    logic [6:0]  exp_col;
    logic [4:0]  exp_row;
    logic        exp_ft;

    // Hand-derived windows (bit c = column c)
    logic [6:0] tab0_p0;
    logic [6:0] tab4_p0;
    logic [6:0] tab0_p15;
    logic [6:0] tab4_p15;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Pixels of column c for pointer p: buf[r][15 - ((p + c) mod 16)].
    function automatic logic [4:0] model_rows(input logic [3:0] p, input logic [2:0] c);
        logic [3:0] k;
        logic [4:0] v;
        k = p + {1'b0, c};
        for (int r = 0; r < 5; r++) begin
            v[r] = m_buf[r][4'd15 - k];
        end
        return v;
    endfunction

    // ---------------- driver: one clock plus reference check ----------------
    task automatic tick();
        logic [2:0]  pre_col;
        logic [3:0]  pre_ptr;
        logic        pre_rst;
        logic [1:0]  pre_mode;
        logic        pre_ld;
        logic [2:0]  pre_lr;
        logic [15:0] pre_ld_data;
        pre_col     = m_col;
        pre_ptr     = m_ptr;
        pre_rst     = rst;
        pre_mode    = mode;
        pre_ld      = load_en;
        pre_lr      = load_row;
        pre_ld_data = load_data;
        @(posedge clk);
        #1;
        cyc++;
        if (pre_rst) begin
            m_col   = 3'd0;
            m_ptr   = 4'd0;
            for (int r = 0; r < 5; r++) m_buf[r] = 16'h0000;
            exp_col = 7'd0;
            exp_row = 5'd0;
            exp_ft  = 1'b0;
        end else begin
            exp_col = (pre_mode == 2'b00) ? 7'd0 : (7'd1 << pre_col);
            exp_row = (pre_mode == 2'b00) ? 5'd0 : model_rows(pre_ptr, pre_col);
            exp_ft  = (pre_col == 3'd6);
            if (pre_col == 3'd6) begin
                if (pre_mode == 2'b01) m_ptr = m_ptr + 4'd1;
                if (pre_mode == 2'b10) m_ptr = m_ptr - 4'd1;
            end
            m_col = (pre_col == 3'd6) ? 3'd0 : pre_col + 3'd1;
            if (pre_ld && (pre_lr < 3'd5)) m_buf[pre_lr] = pre_ld_data;
        end
        check("col_out", 32'(col_out), 32'(exp_col));
        check("row_out", 32'(row_out), 32'(exp_row));
        check("frame_tick", 32'(frame_tick), 32'(exp_ft));
        if (frame_tick) ft_count++;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        tab0_p0  = 7'b1110101;  // 16'hAEEE positions 0..6
        tab4_p0  = 7'b1110111;  // 16'hEE8E positions 0..6
        tab0_p15 = 7'b1101010;  // 16'hAEEE positions 15,0..5
        tab4_p15 = 7'b1101110;  // 16'hEE8E positions 15,0..5
        ft_count = 0;

        // Reset holds priority over a pending load and a scroll mode
        rst = 1'b1; mode = 2'b01; load_en = 1'b1; load_row = 3'd0; load_data = 16'hFFFF;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_col", 32'(col_out), 32'd0);
            check("rst_row", 32'(row_out), 32'd0);
            check("rst_ft", 32'(frame_tick), 32'd0);
        end
        rst = 1'b0; load_en = 1'b0;
        tick();
        check("rel_col", 32'(col_out), 32'd1);
        check("rel_row", 32'(row_out), 32'd0);
        check("rel_ft", 32'(frame_tick), 32'd0);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("rst_buf_zero", 32'(row_out), 32'd0);
        end

        // Static display at ptr 0
        rst = 1'b1; tick(); rst = 1'b0;
        mode = 2'b11;
        load_en = 1'b1; load_row = 3'd0; load_data = 16'hAEEE; tick();
        load_row = 3'd4; load_data = 16'hEE8E; tick();
        load_en = 1'b0;
        while (m_col != 3'd0) tick();
        for (int f = 0; f < 2; f++) begin
            for (int c = 0; c < 7; c++) begin
                tick();
                check("st_col", 32'(col_out), 32'(7'd1 << c));
                check("st_r0", 32'(row_out[0]), 32'(tab0_p0[c]));
                check("st_r4", 32'(row_out[4]), 32'(tab4_p0[c]));
                check("st_r123", 32'(row_out[3:1]), 32'd0);
                check("st_ft", 32'(frame_tick), 32'(c == 6));
            end
        end

        // Scroll left: 16 steps bring the window back to the start
        mode = 2'b01;
        for (int e = 1; e <= 112; e++) begin
            tick();
            if (e == 8) begin
                check("sl_c0_col", 32'(col_out), 32'd1);
                check("sl_c0_r0", 32'(row_out[0]), 32'd0);
                check("sl_c0_r4", 32'(row_out[4]), 32'd1);
            end
            if (e == 9) begin
                check("sl_c1_r0", 32'(row_out[0]), 32'd1);
                check("sl_c1_r4", 32'(row_out[4]), 32'd1);
            end
        end
        mode = 2'b11;
        for (int c = 0; c < 7; c++) begin
            tick();
            check("sl_wrap_r0", 32'(row_out[0]), 32'(tab0_p0[c]));
            check("sl_wrap_r4", 32'(row_out[4]), 32'(tab4_p0[c]));
        end

        // Scroll right: 0 wraps to 15
        mode = 2'b10;
        repeat (7) tick();
        mode = 2'b11;
        tick();
        check("sr_c0_col", 32'(col_out), 32'd1);
        check("sr_c0_r0", 32'(row_out[0]), 32'd0);
        check("sr_c0_r4", 32'(row_out[4]), 32'd0);
        tick();
        check("sr_c1_r0", 32'(row_out[0]), 32'd1);
        check("sr_c1_r4", 32'(row_out[4]), 32'd1);
        repeat (5) tick();

        // Blank: outputs dark, frame ticks continue, ptr held
        mode = 2'b00;
        ft_count = 0;
        repeat (30) begin
            tick();
            check("blank_col", 32'(col_out), 32'd0);
            check("blank_row", 32'(row_out), 32'd0);
        end
        check("blank_ft_count", 32'(ft_count), 32'd4);
        mode = 2'b11;
        while (m_col != 3'd0) tick();
        for (int c = 0; c < 7; c++) begin
            tick();
            check("unblank_r0", 32'(row_out[0]), 32'(tab0_p15[c]));
            check("unblank_r4", 32'(row_out[4]), 32'(tab4_p15[c]));
        end

        // Out-of-range load row is ignored
        load_en = 1'b1; load_row = 3'd5; load_data = 16'hFFFF; tick();
        load_en = 1'b0;
        repeat (7) begin
            tick();
            check("bad_row", 32'(row_out[3:1]), 32'd0);
        end

        // Load coinciding with a scroll step: ptr 15 -> 0 and row1 = 8000
        while (m_col != 3'd6) tick();
        mode = 2'b01; load_en = 1'b1; load_row = 3'd1; load_data = 16'h8000;
        tick();
        load_en = 1'b0; mode = 2'b11;
        tick();
        check("ls_c0", 32'(row_out), 32'h13);
        tick();
        check("ls_c1", 32'(row_out), 32'h10);

        // Reset mid-scroll clears outputs, buffer and pointer
        mode = 2'b01;
        repeat (10) tick();
        rst = 1'b1; tick();
        check("rm_col", 32'(col_out), 32'd0);
        check("rm_row", 32'(row_out), 32'd0);
        check("rm_ft", 32'(frame_tick), 32'd0);
        rst = 1'b0; mode = 2'b11;
        load_en = 1'b1; load_row = 3'd0; load_data = 16'hAEEE; tick();
        check("rm_first_row", 32'(row_out), 32'd0);
        load_en = 1'b0;
        repeat (6) tick();
        for (int c = 0; c < 7; c++) begin
            tick();
            check("rm_win", 32'(row_out), 32'({4'b0000, tab0_p0[c]}));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
